// File: rtl/s4ga_stream_if.sv
// s4ga_stream_if
//   Stream-side bundle of the s4ga_stream LUT fabric.
//   master : configuration streamer / pad ring driving the fabric
//   slave  : the fabric itself
// Signals:
//   si         [SI_W] configuration segment
//   si_valid          segment present, beat accepted when high
//   inputs     [I]    FPGA inputs, sampled on accepted beats
//   outputs    [O]    FPGA outputs
//   out_valid         outputs hold a completed frame
//   frame_done        one-cycle pulse at frame completion
//   debug             evaluated input/output trace
interface s4ga_stream_if #(
    parameter int SI_W = 4,
    parameter int I    = 2,
    parameter int O    = 7
);
    logic [SI_W-1:0] si;
    logic            si_valid;
    logic [I-1:0]    inputs;
    logic [O-1:0]    outputs;
    logic            out_valid;
    logic            frame_done;
    logic            debug;

    modport master (
        output si, si_valid, inputs,
        input  outputs, out_valid, frame_done, debug
    );

    modport slave (
        input  si, si_valid, inputs,
        output outputs, out_valid, frame_done, debug
    );
endinterface

// File: rtl/s4ga_stream.sv
// s4ga_stream
//   Serial-configured LUT fabric. Each frame evaluates N K-input LUTs one
//   at a time from a segmented configuration stream: K input indices of
//   IDX_SEGS segments each, followed by a 2**K-bit mask in MASK_SEGS
//   segments. Results circulate in an N-bit ring so later LUTs can read
//   earlier ones. The stream is stallable through si_valid.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-low reset
//   bus  : s4ga_stream_if slave (si, si_valid, inputs -> outputs,
//          out_valid, frame_done, debug)
module s4ga_stream #(
    parameter int N    = 241,
    parameter int K    = 5,
    parameter int I    = 2,
    parameter int O    = 7,
    parameter int SI_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    s4ga_stream_if.slave  bus
);
    localparam int IDX_W     = $clog2(3 + I + N);
    localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
    localparam int MASK_SEGS = (2 ** K) / SI_W;
    localparam int LL        = K * IDX_SEGS + MASK_SEGS;
    localparam int FW        = IDX_SEGS * SI_W;
    localparam int NW        = (N > 1) ? $clog2(N) : 1;
    localparam int KW        = $clog2(K + 1);
    localparam int SEG_MAX   = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
    localparam int SGW       = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;

    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Each LUT advances the ring by LL positions; coprimality guarantees a
    // result survives exactly one full frame before being overwritten.
    if (gcd(N, LL) != 1) begin : g_chk_coprime
        $error("s4ga_stream: N and LL must be coprime");
    end
    if (K < 2) begin : g_chk_k
        $error("s4ga_stream: K must be at least 2");
    end
    if (N < 2 || O < 1 || O > N) begin : g_chk_o
        $error("s4ga_stream: need N >= 2 and 1 <= O <= N");
    end
    if ((SI_W & (SI_W - 1)) != 0 || SI_W > 2 ** K) begin : g_chk_siw
        $error("s4ga_stream: SI_W must be a power of 2 no larger than 2**K");
    end

    logic [N-1:0]    luts_q, luts_d;
    logic [K-1:0]    ins_q, ins_d;
    logic [FW-1:0]   idx_acc_q, idx_acc_d;
    logic            q_q, q_d;
    logic            lut_q, lut_d;
    logic            half_q, half_d;
    logic [NW-1:0]   n_q, n_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SGW-1:0]  seg_q, seg_d;
    logic [O-1:0]    outputs_q, outputs_d;
    logic            out_valid_q, out_valid_d;
    logic            frame_done_q, frame_done_d;
    logic            debug_q, debug_d;

    logic            in_mask;
    logic            last_idx;
    logic            last_mask;
    logic [FW-1:0]   idx_full;
    logic            dec_bit;
    logic [K-1:0]    half_idx;
    int              mask_base;
    logic            lut_now;
    logic            half_now;
    logic [O-1:0]    frame_taps;

    // Beat decode: index assembly, input selection and mask-bit pickup.
    // lut_now/half_now fall back to the captured values when the current
    // segment does not carry the addressed bit, so on the final mask beat
    // they give the correct result whichever segment held it.
    always_comb begin
        in_mask   = (k_q == KW'(K));
        last_idx  = !in_mask && (seg_q == SGW'(IDX_SEGS - 1));
        last_mask = in_mask && (seg_q == SGW'(MASK_SEGS - 1));
        idx_full  = (idx_acc_q << SI_W) | FW'(bus.si);

        dec_bit = 1'b0;
        if (idx_full == FW'(1)) begin
            dec_bit = 1'b1;
        end else if (idx_full == FW'(2)) begin
            dec_bit = q_q;
        end
        for (int j = 0; j < I; j++) begin
            if (idx_full == FW'(3 + j)) begin
                dec_bit = bus.inputs[j];
            end
        end
        for (int p = 0; p < N; p++) begin
            if (idx_full == FW'(3 + I + p)) begin
                dec_bit = luts_q[p];
            end
        end

        half_idx  = {1'b0, ins_q[K-2:0]};
        mask_base = (MASK_SEGS - 1 - int'(seg_q)) * SI_W;
        lut_now   = lut_q;
        half_now  = half_q;
        for (int b = 0; b < SI_W; b++) begin
            if (int'(ins_q) == mask_base + b) begin
                lut_now = bus.si[b];
            end
            if (int'(half_idx) == mask_base + b) begin
                half_now = bus.si[b];
            end
        end
    end

    // Frame-end output taps: LUT N-1-j sits at ring position (LL*j-1) mod N
    // when the last LUT of the frame completes; the last LUT itself has not
    // entered the ring yet and is taken directly.
    assign frame_taps[0] = lut_now;
    for (genvar j = 1; j < O; j++) begin : g_tap
        localparam int TAP = ((LL * j - 1) % N + N) % N;
        assign frame_taps[j] = luts_q[TAP];
    end

    // Next-state logic. Nothing moves on a stall except the two pulse
    // outputs, which drop back to zero.
    always_comb begin
        luts_d       = luts_q;
        ins_d        = ins_q;
        idx_acc_d    = idx_acc_q;
        q_d          = q_q;
        lut_d        = lut_q;
        half_d       = half_q;
        n_d          = n_q;
        k_d          = k_q;
        seg_d        = seg_q;
        outputs_d    = outputs_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        debug_d      = 1'b0;

        if (bus.si_valid) begin
            luts_d = {luts_q[N-2:0], luts_q[N-1]};
            if (!in_mask) begin
                idx_acc_d = idx_full;
                if (last_idx) begin
                    ins_d   = {ins_q[K-2:0], dec_bit};
                    debug_d = dec_bit;
                    k_d     = k_q + KW'(1);
                    seg_d   = '0;
                end else begin
                    seg_d = seg_q + SGW'(1);
                end
            end else if (!last_mask) begin
                lut_d  = lut_now;
                half_d = half_now;
                seg_d  = seg_q + SGW'(1);
            end else begin
                luts_d  = {luts_q[N-2:0], lut_now};
                q_d     = half_now;
                debug_d = lut_now;
                k_d     = '0;
                seg_d   = '0;
                if (n_q == NW'(N - 1)) begin
                    n_d          = '0;
                    outputs_d    = frame_taps;
                    out_valid_d  = 1'b1;
                    frame_done_d = 1'b1;
                end else begin
                    n_d = n_q + NW'(1);
                end
            end
        end
    end

    // State registers; reset wins over an accepted beat and discards any
    // partially configured LUT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            luts_q       <= '0;
            ins_q        <= '0;
            idx_acc_q    <= '0;
            q_q          <= 1'b0;
            lut_q        <= 1'b0;
            half_q       <= 1'b0;
            n_q          <= '0;
            k_q          <= '0;
            seg_q        <= '0;
            outputs_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            debug_q      <= 1'b0;
        end else begin
            luts_q       <= luts_d;
            ins_q        <= ins_d;
            idx_acc_q    <= idx_acc_d;
            q_q          <= q_d;
            lut_q        <= lut_d;
            half_q       <= half_d;
            n_q          <= n_d;
            k_q          <= k_d;
            seg_q        <= seg_d;
            outputs_q    <= outputs_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            debug_q      <= debug_d;
        end
    end

    assign bus.outputs    = outputs_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.debug      = debug_q;
endmodule

// File: tb/tb_s4ga_stream.sv
// tb_s4ga_stream
//   Directed bench for s4ga_stream. A LUT-level reference model pushes
//   the expected debug trace (one entry per accepted beat) and the expected
//   frame outputs into queues as each frame is issued; they are popped as
//   the DUT accepts beats and completes frames.
module tb_s4ga_stream;
    localparam int N         = 241;
    localparam int K         = 5;
    localparam int I         = 2;
    localparam int O         = 7;
    localparam int SI_W      = 4;
    localparam int IDX_W     = $clog2(3 + I + N);
    localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
    localparam int MASK_SEGS = (2 ** K) / SI_W;
    localparam int LL        = K * IDX_SEGS + MASK_SEGS;
    localparam int MW        = 2 ** K;
    localparam int FRAME     = N * LL;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    s4ga_stream_if #(.SI_W(SI_W), .I(I), .O(O)) bus ();

    s4ga_stream #(.N(N), .K(K), .I(I), .O(O), .SI_W(SI_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            cfg_idx  [N][K];
    logic [MW-1:0] cfg_mask [N];

    logic          m_q;
    logic          hist [int];
    int            g_base;
    logic          exp_dbg_q [$];
    logic [O-1:0]  exp_out_q [$];

    int tests_run    = 0;
    int tests_failed = 0;
    int fd_count     = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value of ring position p as seen by index i of global LUT g: the
    // unique LUT among the previous N whose result has drifted to p.
    function automatic logic ringValue(input int g, input int i, input int p);
        int t;
        t = g * LL + i * IDX_SEGS + IDX_SEGS - 1;
        for (int gs = g - 1; gs >= g - N; gs--) begin
            if ((t - (gs + 1) * LL) % N == p) begin
                if (gs < 0) return 1'b0;
                return hist.exists(gs) ? hist[gs] : 1'b0;
            end
        end
        return 1'b0;
    endfunction

    task automatic modelFrame(input logic [I-1:0] in_val);
        logic         res [N];
        logic [O-1:0] e;
        for (int m = 0; m < N; m++) begin
            int         g;
            logic [K-1:0] ins;
            logic       lut;
            logic       half;
            g   = g_base + m;
            ins = '0;
            for (int i = 0; i < K; i++) begin
                int   idx;
                logic d;
                idx = cfg_idx[m][i];
                d   = 1'b0;
                if (idx == 1) d = 1'b1;
                else if (idx == 2) d = m_q;
                else if (idx >= 3 && idx < 3 + I) d = in_val[idx-3];
                else if (idx >= 3 + I && idx < 3 + I + N) d = ringValue(g, i, idx - 3 - I);
                ins = {ins[K-2:0], d};
                for (int s = 0; s < IDX_SEGS - 1; s++) exp_dbg_q.push_back(1'b0);
                exp_dbg_q.push_back(d);
            end
            lut  = cfg_mask[m][ins];
            half = cfg_mask[m][{1'b0, ins[K-2:0]}];
            for (int s = 0; s < MASK_SEGS - 1; s++) exp_dbg_q.push_back(1'b0);
            exp_dbg_q.push_back(lut);
            m_q     = half;
            hist[g] = lut;
            res[m]  = lut;
        end
        for (int j = 0; j < O; j++) e[j] = res[N-1-j];
        exp_out_q.push_back(e);
        g_base += N;
    endtask

    function automatic logic [SI_W-1:0] segValue(input int m, input int b);
        int            v;
        logic [MW-1:0] mv;
        if (b < K * IDX_SEGS) begin
            v = cfg_idx[m][b / IDX_SEGS] >> ((IDX_SEGS - 1 - b % IDX_SEGS) * SI_W);
            return v[SI_W-1:0];
        end
        mv = cfg_mask[m] >> ((MASK_SEGS - 1 - (b - K * IDX_SEGS)) * SI_W);
        return mv[SI_W-1:0];
    endfunction

    task automatic checkOutput(input logic accepted, input logic fin);
        logic e;
        e = 1'b0;
        if (accepted) begin
            if (exp_dbg_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $error("[TB] FAIL scoreboard: observed empty debug queue expected an entry");
            end else begin
                e = exp_dbg_q.pop_front();
            end
        end
        checkVal("debug", {31'b0, bus.debug}, {31'b0, e});
        checkVal("frame_done", {31'b0, bus.frame_done}, {31'b0, accepted && fin});
        if (bus.frame_done === 1'b1) fd_count++;
        if (accepted && fin) begin
            if (exp_out_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $error("[TB] FAIL scoreboard: observed empty outputs queue expected an entry");
            end else begin
                checkVal("outputs", {25'b0, bus.outputs}, {25'b0, exp_out_q.pop_front()});
            end
            checkVal("out_valid", {31'b0, bus.out_valid}, 32'd1);
        end
    endtask

    task automatic driveCycle(input logic valid, input logic [SI_W-1:0] seg,
                              input logic [I-1:0] in_val, input bit checked, input logic fin);
        @(negedge clk);
        bus.si_valid = valid;
        bus.si       = valid ? seg : SI_W'($urandom);
        bus.inputs   = valid ? in_val : I'($urandom);
        @(posedge clk);
        #1;
        if (checked) checkOutput(valid, fin);
    endtask

    task automatic applyStimulus(input int stall_pct, input logic [I-1:0] in_val,
                                 input bit checked, input int n_beats);
        if (checked) modelFrame(in_val);
        for (int bt = 0; bt < n_beats; bt++) begin
            while (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                driveCycle(1'b0, '0, in_val, checked, 1'b0);
            end
            driveCycle(1'b1, segValue(bt / LL, bt % LL), in_val, checked, bt == FRAME - 1);
        end
        @(negedge clk);
        bus.si_valid = 1'b0;
    endtask

    task automatic setUniform(input int idx, input logic [MW-1:0] mask);
        for (int m = 0; m < N; m++) begin
            for (int i = 0; i < K; i++) cfg_idx[m][i] = idx;
            cfg_mask[m] = mask;
        end
    endtask

    task automatic resetModel();
        m_q    = 1'b0;
        g_base = 0;
        hist.delete();
        exp_dbg_q.delete();
        exp_out_q.delete();
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int            fd_before;
        int            ring_p;
        logic [I-1:0]  rin [3];
        int            ridx [3][N][K];
        logic [MW-1:0] rmask [3][N];

        rst          = 1'b0;
        bus.si       = '0;
        bus.si_valid = 1'b0;
        bus.inputs   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_outputs", {25'b0, bus.outputs}, 32'd0);
        checkVal("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkVal("reset_frame_done", {31'b0, bus.frame_done}, 32'd0);
        checkVal("reset_debug", {31'b0, bus.debug}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        resetModel();

        // All-ones inputs selecting mask bit 31
        setUniform(1, 32'h8000_0000);
        applyStimulus(0, 2'b00, 1, FRAME);
        checkVal("A_outputs", {25'b0, bus.outputs}, 32'h7F);
        checkVal("A_frame_done_count", fd_count, 1);

        setUniform(0, 32'h0000_0000);
        applyStimulus(0, 2'b11, 1, FRAME);
        checkVal("zero_outputs", {25'b0, bus.outputs}, 32'h00);

        setUniform(1, 32'h8000_0000);
        applyStimulus(0, 2'b00, 1, FRAME);
        checkVal("A2_outputs", {25'b0, bus.outputs}, 32'h7F);

        setUniform(1, 32'h7FFF_FFFF);
        applyStimulus(0, 2'b00, 1, FRAME);
        checkVal("B_outputs", {25'b0, bus.outputs}, 32'h00);

        // LUT0 buffers inputs[0]; LUT240 buffers LUT0 from its ring slot
        setUniform(0, 32'h0000_0000);
        cfg_idx[0][0] = 3;
        cfg_mask[0]   = 32'h0001_0000;
        ring_p        = ((N - 1) * LL + IDX_SEGS - 1 - LL) % N;
        cfg_idx[N-1][0] = 3 + I + ring_p;
        cfg_mask[N-1]   = 32'h0001_0000;
        applyStimulus(0, 2'b01, 1, FRAME);
        checkVal("buf_in1_outputs", {25'b0, bus.outputs}, 32'h01);
        applyStimulus(0, 2'b00, 1, FRAME);
        checkVal("buf_in0_outputs", {25'b0, bus.outputs}, 32'h00);

        // Random configuration: three frames with 50% stalls, then unstalled
        for (int f = 0; f < 3; f++) begin
            rin[f] = I'($urandom);
            for (int m = 0; m < N; m++) begin
                for (int i = 0; i < K; i++) begin
                    ridx[f][m][i] = ($urandom_range(1) == 0) ? $urandom_range(4) : $urandom_range(255);
                end
                rmask[f][m] = MW'($urandom);
            end
        end
        fd_before = fd_count;
        for (int f = 0; f < 3; f++) begin
            cfg_idx  = ridx[f];
            cfg_mask = rmask[f];
            applyStimulus(50, rin[f], 1, FRAME);
        end
        checkVal("stall_frame_done_count", fd_count - fd_before, 3);
        for (int f = 0; f < 3; f++) begin
            cfg_idx  = ridx[f];
            cfg_mask = rmask[f];
            applyStimulus(0, rin[f], 1, FRAME);
        end

        // Reset in place of beat 9 of LUT 120, with a beat on offer
        setUniform(1, 32'h8000_0000);
        applyStimulus(0, 2'b00, 0, 120 * LL + 9);
        @(negedge clk);
        rst          = 1'b0;
        bus.si_valid = 1'b1;
        bus.si       = '1;
        @(posedge clk);
        #1;
        checkVal("midreset_outputs", {25'b0, bus.outputs}, 32'd0);
        checkVal("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkVal("midreset_frame_done", {31'b0, bus.frame_done}, 32'd0);
        checkVal("midreset_debug", {31'b0, bus.debug}, 32'd0);
        @(negedge clk);
        rst          = 1'b1;
        bus.si_valid = 1'b0;
        resetModel();
        applyStimulus(0, 2'b00, 1, FRAME);
        checkVal("restart_outputs", {25'b0, bus.outputs}, 32'h7F);

        // Out-of-range index decodes to 0
        setUniform(255, 32'hAAAA_AAAA);
        applyStimulus(0, 2'b11, 1, FRAME);
        checkVal("oor_outputs", {25'b0, bus.outputs}, 32'h00);
        checkVal("oor_out_valid", {31'b0, bus.out_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
